// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access sizes, FSM states,
// and the store byte-enable lookup.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    // Low-aligned byte-lane enables; the memory rotates lanes by address,
    // so a store only ever uses the bottom lanes. Size 11 behaves as word.
    function automatic logic [3:0] size_to_be(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_to_be = 4'b0001;
            SZ_HALF: size_to_be = 4'b0011;
            default: size_to_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load data extension: selects the low byte/half/word of the rotated memory
// read data and sign- or zero-extends it to 32 bits.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    // Extend the addressed field; the sign bit is suppressed for unsigned loads
    always_comb begin
        data_o = data_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{~uns_i & data_i[7]}},  data_i[7:0]};
            SZ_HALF: data_o = {{16{~uns_i & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU = A, DMA = B) round-robin arbiter in front of a
// rotating byte-lane data memory with 1-cycle synchronous read.
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN adds a_err/b_err ports and
// suppresses misaligned half/word accesses (granted, no write, no response).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12
)
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_size,
    input  logic        a_uns,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_size,
    input  logic        b_uns,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [31:0] a_rdata,
    output logic [31:0] b_rdata,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic        a_err,
    output logic        b_err,
`endif
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wr,
    input  logic [31:0] mem_rdata
);

    state_e              state_q, state_d;
    logic                last_b_q;      // 1 = B was granted most recently
    logic                sel_b_q;       // current access belongs to B
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         a_rdata_q, b_rdata_q;
    logic                mis_q;         // latched access is misaligned (check build only)

    logic                req_any;
    logic                pick_b;
    logic                win_we;
    logic [1:0]          win_size;
    logic                win_uns;
    logic [31:0]         win_addr;
    logic [31:0]         win_wdata;
    logic [31:0]         ext_data;
    logic                in_issue, in_resp;

    // Round-robin pick and mux of the winning requester's fields
    always_comb begin
        req_any   = a_req | b_req;
        pick_b    = b_req & (~a_req | ~last_b_q);
        win_we    = pick_b ? b_we    : a_we;
        win_size  = pick_b ? b_size  : a_size;
        win_uns   = pick_b ? b_uns   : a_uns;
        win_addr  = pick_b ? b_addr  : a_addr;
        win_wdata = pick_b ? b_wdata : a_wdata;
    end

    // Next-state: stores and suppressed accesses finish after ISSUE, loads add RESP
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (we_q || mis_q) ? ST_IDLE : ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, arbitration pointer, latched request and held response data
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            sel_b_q   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req_any) begin
                sel_b_q  <= pick_b;
                last_b_q <= pick_b;
                we_q     <= win_we;
                size_q   <= win_size;
                uns_q    <= win_uns;
                addr_q   <= win_addr[ADDR_W-1:0];
                wdata_q  <= win_wdata;
            end
            if (state_q == ST_RESP) begin
                if (sel_b_q) b_rdata_q <= ext_data;
                else         a_rdata_q <= ext_data;
            end
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    // Classify the winning access as misaligned when it is accepted
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mis_q <= 1'b0;
        end else if (state_q == ST_IDLE && req_any) begin
            mis_q <= (win_size == SZ_HALF && win_addr[0]) ||
                     (win_size[1] && win_addr[1:0] != 2'b00);
        end
    end
    assign a_err = in_issue & ~sel_b_q & mis_q;
    assign b_err = in_issue &  sel_b_q & mis_q;
`else
    assign mis_q = 1'b0;
`endif

    // Address bits above ADDR_W are deliberately dropped
    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^win_addr[31:ADDR_W];
        end
    endgenerate

    dmem_load_ext u_load_ext (
        .size_i (size_q),
        .uns_i  (uns_q),
        .data_i (mem_rdata),
        .data_o (ext_data)
    );

    assign in_issue  = (state_q == ST_ISSUE);
    assign in_resp   = (state_q == ST_RESP);
    assign mem_addr  = 32'(addr_q);
    assign mem_wdata = wdata_q;
    assign mem_wr    = (in_issue && we_q && !mis_q) ? size_to_be(size_q) : 4'b0000;
    assign a_gnt     = in_issue & ~sel_b_q;
    assign b_gnt     = in_issue &  sel_b_q;
    assign a_rvalid  = in_resp  & ~sel_b_q;
    assign b_rvalid  = in_resp  &  sel_b_q;
    assign a_rdata   = a_rvalid ? ext_data : a_rdata_q;
    assign b_rdata   = b_rvalid ? ext_data : b_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a rotating little-endian byte memory.
// Build with DMEM_ARB_ALIGN_CHECK_EN defined to exercise the error ports.
module tb_dmem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        a_req = 0, a_we = 0, a_uns = 0;
    logic [1:0]  a_size = 0;
    logic [31:0] a_addr = 0, a_wdata = 0;
    logic        b_req = 0, b_we = 0, b_uns = 0;
    logic [1:0]  b_size = 0;
    logic [31:0] b_addr = 0, b_wdata = 0;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic        a_err, b_err;
`endif
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wr;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:4095];

    always #5 Clk = ~Clk;

    dmem_arbiter #(.ADDR_W(12)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_uns(a_uns),
        .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_uns(b_uns),
        .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        .a_err(a_err), .b_err(b_err),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    // Rotating byte-lane memory: lane k maps to byte address addr+k
    always_ff @(posedge Clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_wr[k]) mem[12'(mem_addr[11:0] + 12'(k))] <= mem_wdata[8*k +: 8];
        end
        mem_rdata <= {mem[12'(mem_addr[11:0] + 12'd3)], mem[12'(mem_addr[11:0] + 12'd2)],
                      mem[12'(mem_addr[11:0] + 12'd1)], mem[mem_addr[11:0]]};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic use_b, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (!use_b) begin
            a_req = 1; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = 1; b_we = we; b_size = size; b_uns = uns; b_addr = addr; b_wdata = wdata;
        end
    endtask

    task automatic drop_reqs();
        a_req = 0;
        b_req = 0;
    endtask

    // One access from an idle arbiter: grant one cycle after the request edge,
    // and for loads a response the following cycle.
    task automatic access(input string tag, input logic use_b, input logic we,
                          input logic [1:0] size, input logic uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_wr,
                          input logic [31:0] exp_rdata);
        int lat;
        logic g;
        logic [31:0] rd;
        @(negedge Clk);
        drive_req(use_b, we, size, uns, addr, wdata);
        lat = 0;
        g = 0;
        while (!g && lat < 8) begin
            @(negedge Clk);
            lat++;
            g = use_b ? b_gnt : a_gnt;
        end
        check_val({tag, "_gnt_lat"}, 32'(lat), 32'd1);
        check_val({tag, "_mem_wr"}, 32'(mem_wr), 32'(exp_wr));
        check_val({tag, "_mem_addr"}, mem_addr, addr & 32'h0000_0FFF);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        check_val({tag, "_err"}, 32'(use_b ? b_err : a_err),
                  32'((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00)));
`endif
        drop_reqs();
        rd = 32'h0;
        if (!we) begin
            @(negedge Clk);
            check_val({tag, "_rvalid"}, 32'(use_b ? b_rvalid : a_rvalid), 32'd1);
            rd = use_b ? b_rdata : a_rdata;
            check_val({tag, "_rdata"}, rd, exp_rdata);
        end
        $display("txn %s req=%s we=%0d size=%0d uns=%0d addr=0x%03h wdata=0x%08h rdata=0x%08h",
                 tag, use_b ? "B" : "A", we, size, uns, addr[11:0], wdata, rd);
    endtask

    initial begin
        int ng;
        int both;
        int noise;
        logic [3:0] seq;

        // Reset state
        repeat (2) @(negedge Clk);
        check_val("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
        check_val("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        check_val("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        check_val("rst_a_rdata", a_rdata, 32'd0);
        Rst_n = 1'b1;

        // Word store then sign-extended byte load, rdata hold, half unsigned load
        access("st_w10", 0, 1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        access("ld_b10", 0, 0, 2'b00, 0, 32'h0000_0010, 32'h0, 4'b0000, 32'hFFFF_FFEF);
        @(negedge Clk);
        check_val("hold_rvalid", 32'(a_rvalid), 32'd0);
        check_val("hold_rdata", a_rdata, 32'hFFFF_FFEF);
        access("ld_h12u", 0, 0, 2'b01, 1, 32'h0000_0012, 32'h0, 4'b0000, 32'h0000_DEAD);
        access("ld_h10s", 1, 0, 2'b01, 0, 32'h0000_0010, 32'h0, 4'b0000, 32'hFFFF_BEEF);
        access("ld_w10", 1, 0, 2'b11, 0, 32'hFFFF_F010, 32'h0, 4'b0000, 32'hDEAD_BEEF);

        // Byte store/load sign cases
        access("st_b21a", 0, 1, 2'b00, 0, 32'h0000_0021, 32'h0000_007F, 4'b0001, 32'h0);
        access("ld_b21a", 0, 0, 2'b00, 0, 32'h0000_0021, 32'h0, 4'b0000, 32'h0000_007F);
        access("st_b21b", 1, 1, 2'b00, 0, 32'h0000_0021, 32'h1234_5680, 4'b0001, 32'h0);
        access("ld_b21b", 0, 0, 2'b00, 0, 32'h0000_0021, 32'h0, 4'b0000, 32'hFFFF_FF80);
        access("ld_b21u", 1, 0, 2'b00, 1, 32'h0000_0021, 32'h0, 4'b0000, 32'h0000_0080);
        access("st_h30", 0, 1, 2'b01, 0, 32'h0000_0030, 32'hFFFF_1234, 4'b0011, 32'h0);
        access("ld_w30", 0, 0, 2'b10, 0, 32'h0000_0030, 32'h0, 4'b0000, 32'h0000_1234 | 32'(mem[12'h32]) << 16 | 32'(mem[12'h33]) << 24);

        // Misaligned word store from B
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        access("st_w13", 1, 1, 2'b10, 0, 32'h0000_0013, 32'hCAFE_F00D, 4'b0000, 32'h0);
        @(negedge Clk);
        check_val("mis_quiet", 32'({b_rvalid, mem_wr}), 32'd0);
        access("ld_b13", 0, 0, 2'b00, 1, 32'h0000_0013, 32'h0, 4'b0000, 32'h0000_00DE);
`else
        access("st_w13", 1, 1, 2'b10, 0, 32'h0000_0013, 32'hCAFE_F00D, 4'b1111, 32'h0);
        access("ld_w13", 0, 0, 2'b10, 0, 32'h0000_0013, 32'h0, 4'b0000, 32'hCAFE_F00D);
`endif

        // Round robin with both requests held; fresh reset favours A
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        drive_req(0, 1, 2'b10, 0, 32'h0000_0100, 32'h0000_00A1);
        drive_req(1, 1, 2'b10, 0, 32'h0000_0104, 32'h0000_00B2);
        ng = 0;
        both = 0;
        seq = 4'b0;
        for (int i = 0; i < 20 && ng < 4; i++) begin
            @(negedge Clk);
            if (a_gnt && b_gnt) both++;
            if (a_gnt) begin seq[ng] = 1'b0; ng++; end
            else if (b_gnt) begin seq[ng] = 1'b1; ng++; end
        end
        drop_reqs();
        check_val("rr_count", 32'(ng), 32'd4);
        check_val("rr_both", 32'(both), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rr_grant%0d", i), 32'(seq[i]), 32'(i % 2));
        end
        $display("txn rr grants=%b (bit0 first, 0=A 1=B)", seq);
        access("ld_w104", 0, 0, 2'b10, 0, 32'h0000_0104, 32'h0, 4'b0000, 32'h0000_00B2);

        // Reset during the ISSUE of a store aborts it
        access("st_w40", 0, 1, 2'b10, 0, 32'h0000_0040, 32'h1122_3344, 4'b1111, 32'h0);
        @(negedge Clk);
        drive_req(0, 1, 2'b10, 0, 32'h0000_0040, 32'hAABB_CCDD);
        @(negedge Clk);
        check_val("rst_issue_gnt", 32'(a_gnt), 32'd1);
        Rst_n = 1'b0;
        #1;
        check_val("rst_abort_gnt", 32'(a_gnt), 32'd0);
        check_val("rst_abort_wr", 32'(mem_wr), 32'd0);
        drop_reqs();
        @(negedge Clk);
        Rst_n = 1'b1;
        noise = 0;
        repeat (3) begin
            @(negedge Clk);
            if (a_gnt || b_gnt || a_rvalid || b_rvalid || mem_wr != 4'b0) noise++;
        end
        check_val("rst_quiet", 32'(noise), 32'd0);
        $display("txn rst_abort store 0xAABBCCDD to 0x040 aborted");
        access("ld_w40", 0, 0, 2'b10, 0, 32'h0000_0040, 32'h0, 4'b0000, 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends with a summary
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
